// File: rtl/cgra_tile_pkg.sv
// Shared definitions for the CGRA PE tile: opcodes, ALU function codes,
// sequencing states and instruction field offsets.
package cgra_tile_pkg;

    localparam logic [2:0] OP_ALU   = 3'b000;
    localparam logic [2:0] OP_SEND  = 3'b001;
    localparam logic [2:0] OP_OUT   = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b011;
    localparam logic [2:0] OP_RECV  = 3'b100;
    localparam logic [2:0] OP_LOAD  = 3'b101;
    localparam logic [2:0] OP_IMM   = 3'b110;
    localparam logic [2:0] OP_NOP   = 3'b111;

    localparam logic [3:0] FN_ADD = 4'h0;
    localparam logic [3:0] FN_SUB = 4'h1;
    localparam logic [3:0] FN_MUL = 4'h2;
    localparam logic [3:0] FN_SLL = 4'h3;
    localparam logic [3:0] FN_SRL = 4'h4;
    localparam logic [3:0] FN_LT  = 4'h5;
    localparam logic [3:0] FN_GT  = 4'h6;
    localparam logic [3:0] FN_EQ  = 4'h7;
    localparam logic [3:0] FN_OR  = 4'h8;
    localparam logic [3:0] FN_AND = 4'h9;
    localparam logic [3:0] FN_XOR = 4'hA;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_SEND,
        S_RECV,
        S_MREQ,
        S_MRSP
    } tile_state_e;

    // Instruction layout, LSB first: op, rd, rs1, rs2, dir, func, addr, imm.
    function automatic int unsigned rd_lo();
        return 3;
    endfunction

    function automatic int unsigned rs1_lo(input int unsigned rw);
        return 3 + rw;
    endfunction

    function automatic int unsigned rs2_lo(input int unsigned rw);
        return 3 + 2 * rw;
    endfunction

    function automatic int unsigned dir_lo(input int unsigned rw);
        return 3 + 3 * rw;
    endfunction

    function automatic int unsigned func_lo(input int unsigned rw, input int unsigned dw);
        return 3 + 3 * rw + dw;
    endfunction

    function automatic int unsigned addr_lo(input int unsigned rw, input int unsigned dw);
        return 7 + 3 * rw + dw;
    endfunction

    function automatic int unsigned imm_lo(input int unsigned rw, input int unsigned dw,
                                           input int unsigned aw);
        return 7 + 3 * rw + dw + aw;
    endfunction

    function automatic int unsigned instr_width(input int unsigned rw, input int unsigned dw,
                                                input int unsigned aw, input int unsigned data_w);
        return 7 + 3 * rw + dw + aw + data_w;
    endfunction

endpackage

// File: rtl/cgra_pe_alu.sv
// Combinational ALU for the CGRA PE tile; results wrap modulo 2^DATA_W,
// compares are unsigned and return 0/1.
module cgra_pe_alu
    import cgra_tile_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [3:0]        func,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    localparam int unsigned SW = $clog2(DATA_W);

    logic [SW-1:0] sh;
    assign sh = b[SW-1:0];

    always_comb begin
        y = '0;
        case (func)
            FN_ADD:  y = a + b;
            FN_SUB:  y = a - b;
            FN_MUL:  y = a * b;
            FN_SLL:  y = a << sh;
            FN_SRL:  y = a >> sh;
            FN_LT:   y = DATA_W'(a < b);
            FN_GT:   y = DATA_W'(a > b);
            FN_EQ:   y = DATA_W'(a == b);
            FN_OR:   y = a | b;
            FN_AND:  y = a & b;
            FN_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/cgra_pe_tile.sv
// CGRA processing-element tile: one instruction at a time, all links stall on
// valid/ready. Optional stall-cycle counter enabled by TILE_STALL_CNT_EN.
module cgra_pe_tile
    import cgra_tile_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NREG    = 8,
    parameter int unsigned NDIR    = 8,
    parameter int unsigned ADDR_W  = 10,
    localparam int unsigned RW      = $clog2(NREG),
    localparam int unsigned DW      = $clog2(NDIR),
    localparam int unsigned INSTR_W = instr_width(RW, DW, ADDR_W, DATA_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INSTR_W-1:0]       instr,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    output logic [NDIR*DATA_W-1:0]   tx_data,
    output logic [NDIR-1:0]          tx_valid,
    input  logic [NDIR-1:0]          tx_ready,
    input  logic [NDIR*DATA_W-1:0]   rx_data,
    input  logic [NDIR-1:0]          rx_valid,
    output logic [NDIR-1:0]          rx_ready,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_we,
    output logic [ADDR_W-1:0]        mem_req_addr,
    output logic [DATA_W-1:0]        mem_req_wdata,
    input  logic                     mem_rsp_valid,
    input  logic [DATA_W-1:0]        mem_rsp_data,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    output logic [31:0]              stall_cnt
);

    tile_state_e state, state_nx;

    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0]  regs [NREG];

    logic [2:0]        op;
    logic [RW-1:0]     rd, rs1, rs2;
    logic [DW-1:0]     dir;
    logic [3:0]        func;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] imm;

    assign op   = ir[2:0];
    assign rd   = ir[rd_lo() +: RW];
    assign rs1  = ir[rs1_lo(RW) +: RW];
    assign rs2  = ir[rs2_lo(RW) +: RW];
    assign dir  = ir[dir_lo(RW) +: DW];
    assign func = ir[func_lo(RW, DW) +: 4];
    assign addr = ir[addr_lo(RW, DW) +: ADDR_W];
    assign imm  = ir[imm_lo(RW, DW, ADDR_W) +: DATA_W];

    // Out-of-range channel numbers only exist when NDIR is not a power of two.
    logic dir_ok;
    assign dir_ok = ({1'b0, dir} < (DW + 1)'(NDIR));

    logic [DATA_W-1:0] alu_y;

    cgra_pe_alu #(.DATA_W(DATA_W)) u_alu (
        .func (func),
        .a    (regs[rs1]),
        .b    (regs[rs2]),
        .y    (alu_y)
    );

    logic [DATA_W-1:0] rx_sel;
    logic              rx_hit, tx_hit;

    always_comb begin
        rx_sel = '0;
        rx_hit = 1'b0;
        tx_hit = 1'b0;
        for (int unsigned d = 0; d < NDIR; d++) begin
            if (dir == DW'(d)) begin
                rx_sel = rx_data[d*DATA_W +: DATA_W];
                rx_hit = rx_valid[d];
                tx_hit = tx_ready[d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        instr_ready = (state == S_IDLE);
        case (state)
            S_IDLE: if (instr_valid) state_nx = S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_SEND:           state_nx = dir_ok ? S_SEND : S_IDLE;
                    OP_RECV:           state_nx = dir_ok ? S_RECV : S_IDLE;
                    OP_STORE, OP_LOAD: state_nx = S_MREQ;
                    default:           state_nx = S_IDLE;
                endcase
            end
            S_SEND: if (tx_hit) state_nx = S_IDLE;
            S_RECV: if (rx_hit) state_nx = S_IDLE;
            S_MREQ: if (mem_req_ready) state_nx = mem_req_we ? S_IDLE : S_MRSP;
            S_MRSP: if (mem_rsp_valid) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir            <= '0;
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
            tx_data       <= '0;
            tx_valid      <= '0;
            rx_ready      <= '0;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            out_data      <= '0;
            out_valid     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: if (instr_valid) ir <= instr;
                S_EXEC: begin
                    case (op)
                        OP_ALU: regs[rd] <= alu_y;
                        OP_IMM: regs[rd] <= imm;
                        OP_OUT: begin
                            out_data  <= regs[rs1];
                            out_valid <= 1'b1;
                        end
                        OP_SEND: begin
                            for (int unsigned d = 0; d < NDIR; d++) begin
                                if (dir_ok && dir == DW'(d)) begin
                                    tx_data[d*DATA_W +: DATA_W] <= regs[rs1];
                                    tx_valid[d]                 <= 1'b1;
                                end
                            end
                        end
                        OP_RECV: begin
                            for (int unsigned d = 0; d < NDIR; d++) begin
                                if (dir_ok && dir == DW'(d)) rx_ready[d] <= 1'b1;
                            end
                        end
                        OP_STORE, OP_LOAD: begin
                            mem_req_valid <= 1'b1;
                            mem_req_we    <= (op == OP_STORE);
                            mem_req_addr  <= addr;
                            mem_req_wdata <= regs[rs1];
                        end
                        OP_NOP:  ;
                        default: ;
                    endcase
                end
                S_SEND: if (tx_hit) tx_valid <= '0;
                S_RECV: begin
                    if (rx_hit) begin
                        regs[rd] <= rx_sel;
                        rx_ready <= '0;
                    end
                end
                S_MREQ: if (mem_req_ready) mem_req_valid <= 1'b0;
                S_MRSP: if (mem_rsp_valid) regs[rd] <= mem_rsp_data;
                default: ;
            endcase
        end
    end

`ifdef TILE_STALL_CNT_EN
    logic        stalled;
    logic [31:0] stall_q;

    assign stalled = ((state == S_SEND) && !tx_hit) ||
                     ((state == S_RECV) && !rx_hit) ||
                     ((state == S_MREQ) && !mem_req_ready) ||
                     ((state == S_MRSP) && !mem_rsp_valid);

    always_ff @(posedge clk) begin
        if (rst)                          stall_q <= '0;
        else if (stalled && stall_q != '1) stall_q <= stall_q + 32'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_cgra_pe_tile.sv
// Directed, table-driven bench for cgra_pe_tile at default parameters;
// stall expectations follow TILE_STALL_CNT_EN.
module tb_cgra_pe_tile;

    localparam int DATA_W  = 32;
    localparam int NDIR    = 8;
    localparam int ADDR_W  = 10;
    localparam int INSTR_W = 61;

`ifdef TILE_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [INSTR_W-1:0]     instr = '0;
    logic                   instr_valid = 1'b0;
    logic                   instr_ready;
    logic [NDIR*DATA_W-1:0] tx_data;
    logic [NDIR-1:0]        tx_valid;
    logic [NDIR-1:0]        tx_ready = '0;
    logic [NDIR*DATA_W-1:0] rx_data = '0;
    logic [NDIR-1:0]        rx_valid = '0;
    logic [NDIR-1:0]        rx_ready;
    logic                   mem_req_valid;
    logic                   mem_req_ready = 1'b0;
    logic                   mem_req_we;
    logic [ADDR_W-1:0]      mem_req_addr;
    logic [DATA_W-1:0]      mem_req_wdata;
    logic                   mem_rsp_valid = 1'b0;
    logic [DATA_W-1:0]      mem_rsp_data = '0;
    logic [DATA_W-1:0]      out_data;
    logic                   out_valid;
    logic [31:0]            stall_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned exp_stall = 0;

    always #5 clk = ~clk;

    cgra_pe_tile #(.DATA_W(32), .NREG(8), .NDIR(8), .ADDR_W(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .stall_cnt     (stall_cnt)
    );

    typedef struct packed {
        logic [3:0]  func;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    alu_vec_t vecs [14];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [INSTR_W-1:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                              input logic [2:0] rs1, input logic [2:0] rs2,
                                              input logic [2:0] dir, input logic [3:0] fn,
                                              input logic [9:0] addr, input logic [31:0] imm);
        return {imm, addr, fn, dir, rs2, rs1, rd, op};
    endfunction

    // Returns one ns after the accepting edge, i.e. inside the EXEC cycle.
    task automatic issue(input logic [INSTR_W-1:0] ins);
        int n = 0;
        while (instr_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (instr_ready !== 1'b1) begin
            chk("issue_timeout", {255'b0, instr_ready}, 256'd1);
        end else begin
            instr       = ins;
            instr_valid = 1'b1;
            @(posedge clk);
            #1 instr_valid = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_out(input logic [2:0] r, input logic [31:0] exp, input string nm);
        issue(mk(3'b010, 3'd0, r, 3'd0, 3'd0, 4'd0, 10'd0, 32'd0));
        step();
        chk({nm, "_valid"}, {255'b0, out_valid}, 256'd1);
        chk({nm, "_data"}, {224'b0, out_data}, {224'b0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] e;

        vecs[0]  = '{4'h0, 32'd5,          32'd3,          32'd8};
        vecs[1]  = '{4'h1, 32'd3,          32'd5,          32'hFFFF_FFFE};
        vecs[2]  = '{4'h5, 32'd3,          32'd5,          32'd1};
        vecs[3]  = '{4'h6, 32'd3,          32'd5,          32'd0};
        vecs[4]  = '{4'h7, 32'd7,          32'd7,          32'd1};
        vecs[5]  = '{4'h2, 32'h0001_0000,  32'h0001_0001,  32'h0001_0000};
        vecs[6]  = '{4'h3, 32'd1,          32'd31,         32'h8000_0000};
        vecs[7]  = '{4'h3, 32'd1,          32'd33,         32'd2};
        vecs[8]  = '{4'h4, 32'h8000_0000,  32'd4,          32'h0800_0000};
        vecs[9]  = '{4'h8, 32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF};
        vecs[10] = '{4'h9, 32'h0000_00F0,  32'h0000_003C,  32'h0000_0030};
        vecs[11] = '{4'hA, 32'h0000_00FF,  32'h0000_000F,  32'h0000_00F0};
        vecs[12] = '{4'hF, 32'd3,          32'd5,          32'd0};
        vecs[13] = '{4'h0, 32'hFFFF_FFFF,  32'd2,          32'd1};

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_instr_ready", {255'b0, instr_ready}, 256'd1);
        chk("rst_out_valid", {255'b0, out_valid}, 256'd0);
        chk("rst_out_data", {224'b0, out_data}, 256'd0);
        chk("rst_tx", {tx_valid, rx_ready, mem_req_valid, mem_req_we}, 256'd0);
        chk("rst_tx_data", tx_data, 256'd0);
        chk("rst_stall", {224'b0, stall_cnt}, 256'd0);
        rst = 1'b0;

        // ALU table: imm r1, imm r2, alu r3, output r3
        for (int i = 0; i < 14; i++) begin
            issue(mk(3'b110, 3'd1, 3'd0, 3'd0, 3'd0, 4'd0, 10'd0, vecs[i].a));
            issue(mk(3'b110, 3'd2, 3'd0, 3'd0, 3'd0, 4'd0, 10'd0, vecs[i].b));
            issue(mk(3'b000, 3'd3, 3'd1, 3'd2, 3'd0, vecs[i].func, 10'd0, 32'd0));
            do_out(3'd3, vecs[i].exp, $sformatf("alu_vec%0d", i));
        end

        // Test-plan sequence: 5 + 3 with single-cycle out_valid and held out_data
        issue(mk(3'b110, 3'd1, 3'd0, 3'd0, 3'd0, 4'd0, 10'd0, 32'd5));
        chk("exec_instr_ready_low", {255'b0, instr_ready}, 256'd0);
        issue(mk(3'b110, 3'd2, 3'd0, 3'd0, 3'd0, 4'd0, 10'd0, 32'd3));
        issue(mk(3'b000, 3'd3, 3'd1, 3'd2, 3'd0, 4'h0, 10'd0, 32'd0));
        do_out(3'd3, 32'd8, "add_out");
        step();
        chk("out_valid_pulse", {255'b0, out_valid}, 256'd0);
        issue(mk(3'b111, 3'd0, 3'd0, 3'd0, 3'd0, 4'd0, 10'd0, 32'd0));
        step();
        chk("out_data_hold", {224'b0, out_data}, 256'd8);
        chk("nop_no_valid", {255'b0, out_valid}, 256'd0);

        // Send r3 east with tx_ready held low for 4 cycles
        issue(mk(3'b001, 3'd0, 3'd3, 3'd0, 3'd2, 4'd0, 10'd0, 32'd0));
        step();
        e = '0;
        e[2*32 +: 32] = 32'd8;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("send_hold%0d_valid", i), {248'b0, tx_valid}, 256'h04);
            chk($sformatf("send_hold%0d_data", i), tx_data, e);
            chk($sformatf("send_hold%0d_busy", i), {255'b0, instr_ready}, 256'd0);
            step();
        end
        exp_stall += 4;
        tx_ready = 8'h04;
        chk("send_ready_cycle_valid", {248'b0, tx_valid}, 256'h04);
        step();
        tx_ready = '0;
        chk("send_done_valid", {248'b0, tx_valid}, 256'd0);
        chk("send_done_idle", {255'b0, instr_ready}, 256'd1);
        chk("send_data_held", tx_data, e);
        chk("send_stall", {224'b0, stall_cnt}, STALL_EN ? 256'(exp_stall) : 256'd0);

        // Receive channel 5 into r4, noise on channel 0
        rx_valid = 8'h01;
        rx_data[0 +: 32] = 32'hDEAD_BEEF;
        issue(mk(3'b100, 3'd4, 3'd0, 3'd0, 3'd5, 4'd0, 10'd0, 32'd0));
        step();
        chk("recv_ready_a", {248'b0, rx_ready}, 256'h20);
        step();
        chk("recv_ready_b", {248'b0, rx_ready}, 256'h20);
        step();
        exp_stall += 2;
        rx_data[5*32 +: 32] = 32'h0000_1234;
        rx_valid = 8'h21;
        step();
        rx_valid = '0;
        chk("recv_done_ready", {248'b0, rx_ready}, 256'd0);
        chk("recv_done_idle", {255'b0, instr_ready}, 256'd1);
        do_out(3'd4, 32'h0000_1234, "recv_r4");

        // Store r1 (5) to 0x3FF, one cycle of backpressure
        issue(mk(3'b011, 3'd0, 3'd1, 3'd0, 3'd0, 4'd0, 10'h3FF, 32'd0));
        step();
        chk("store_req", {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata},
            {212'b0, 1'b1, 1'b1, 10'h3FF, 32'd5});
        step();
        exp_stall += 1;
        chk("store_req_hold", {255'b0, mem_req_valid}, 256'd1);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("store_done", {mem_req_valid, instr_ready}, 256'b01);

        // Load 0x3FF into r6, response two cycles after the grant
        issue(mk(3'b101, 3'd6, 3'd0, 3'd0, 3'd0, 4'd0, 10'h3FF, 32'd0));
        step();
        chk("load_req", {mem_req_valid, mem_req_we, mem_req_addr}, {244'b0, 1'b1, 1'b0, 10'h3FF});
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("load_wait_rsp", {mem_req_valid, instr_ready}, 256'b00);
        step();
        step();
        exp_stall += 2;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'd5;
        step();
        mem_rsp_valid = 1'b0;
        chk("load_done_idle", {255'b0, instr_ready}, 256'd1);
        chk("mem_stall", {224'b0, stall_cnt}, STALL_EN ? 256'(exp_stall) : 256'd0);
        do_out(3'd6, 32'd5, "load_r6");

        // Reset while waiting for a load response; late response is discarded
        issue(mk(3'b101, 3'd7, 3'd0, 3'd0, 3'd0, 4'd0, 10'h005, 32'd0));
        step();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_stall = 0;
        chk("mrsp_rst_idle", {255'b0, instr_ready}, 256'd1);
        chk("mrsp_rst_req", {255'b0, mem_req_valid}, 256'd0);
        chk("mrsp_rst_stall", {224'b0, stall_cnt}, 256'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hBEEF;
        step();
        mem_rsp_valid = 1'b0;
        chk("mrsp_rst_ignore_rsp", {255'b0, instr_ready}, 256'd1);
        do_out(3'd7, 32'd0, "mrsp_rst_r7");
        do_out(3'd1, 32'd0, "mrsp_rst_r1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cgra_pe_tile.md
# cgra_pe_tile

Parametrised second-generation CGRA processing-element tile. It executes one instruction at a time from the array sequencer: ALU ops, immediate loads, neighbour sends/receives and data-memory loads/stores. All links to neighbours, memory and the sequencer use valid/ready handshakes, so the tile stalls instead of dropping data. It sits in each cell of the CGRA mesh, between the sequencer, the eight-neighbour interconnect and the shared data-memory arbiter.

## Interface
- DATA_W, 32, datapath and register width
- NREG, 8, register-file depth (power of two, ≥2); RW = $clog2(NREG)
- NDIR, 8, neighbour channels (N,NE,E,SE,S,SW,W,NW = 0..7); DW = $clog2(NDIR)
- ADDR_W, 10, data-memory address width
- INSTR_W, derived = 3+3·RW+DW+4+ADDR_W+DATA_W (61 at defaults)
- clk  in  1  clock; one clock
- rst  in  1  synchronous, active-high reset
- instr  in  INSTR_W  instruction; fields LSB-first: op[2:0], rd, rs1, rs2 (RW each), dir (DW), func[3:0], addr (ADDR_W), imm (DATA_W)
- instr_valid / instr_ready  in / out  1  sequencer handshake
- tx_data  out  NDIR·DATA_W  per-direction send data, channel d at [d·DATA_W +: DATA_W]
- tx_valid / tx_ready  out / in  NDIR  per-direction send handshake
- rx_data  in  NDIR·DATA_W  per-direction receive data
- rx_valid / rx_ready  in / out  NDIR  per-direction receive handshake
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_req_we  out  1  1 = store
- mem_req_addr  out  ADDR_W;  mem_req_wdata  out  DATA_W
- mem_rsp_valid  in  1;  mem_rsp_data  in  DATA_W  load response
- out_data  out  DATA_W;  out_valid  out  1  array output
- stall_cnt  out  32  stall-cycle counter (see Configuration)

## Operation
- Opcodes: 000 ALU rd←f(rs1,rs2); 001 send rs1 to channel dir; 010 output rs1; 011 store rs1 to addr; 100 receive channel dir into rd; 101 load addr into rd; 110 rd←imm; 111 NOP.
- ALU func: 0 add, 1 sub, 2 mul (low DATA_W bits), 3 sll, 4 srl (shift amount = rs2[$clog2(DATA_W)-1:0]), 5 lt, 6 gt, 7 eq (unsigned, result 0/1 zero-extended), 8 or, 9 and, A xor, B–F → 0. All wrap modulo 2^DATA_W.
- FSM states: IDLE, EXEC, SEND, RECV, MREQ, MRSP.
- IDLE: instr_ready=1; on instr_valid capture instr, go EXEC.
- EXEC: ALU/imm write rd; output loads out_data, pulses out_valid; NOP does nothing; all of these → IDLE. Send → SEND (registers rs1 onto tx_data slice dir, raises tx_valid[dir]). Receive → RECV. Load/store → MREQ (registers addr, wdata, we).
- SEND: hold tx_valid[dir] and data until tx_ready[dir]; then drop valid, → IDLE. Other tx slices hold their previous data, valid 0.
- RECV: rx_ready[dir]=1 (only that bit); when rx_valid[dir], write rx data to rd, → IDLE.
- MREQ: hold mem_req_valid until mem_req_ready; store → IDLE, load → MRSP.
- MRSP: on mem_rsp_valid write rd, → IDLE. mem_rsp_valid outside MRSP is ignored.
- dir ≥ NDIR (non-power-of-two NDIR): send/receive treated as NOP.

## Timing
- Reset (any state, priority over everything): state IDLE, all registers 0, tx_data 0, tx_valid 0, rx_ready 0, mem_req_* 0, out_data 0, out_valid 0, stall_cnt 0; in-flight memory response discarded.
- Accept at cycle t → EXEC at t+1 → IDLE at t+2; instr_ready low from t+1; throughput one non-stalling instruction per 2 cycles.
- Register write from ALU/imm visible to instruction accepted at t+2.
- Send: tx_valid high from t+2; if tx_ready high at t+2, IDLE at t+3.
- Receive: rx_ready high from t+2; data sampled on the handshake cycle.
- out_valid is exactly one cycle (t+2); out_data holds until next output op.
- Handshake outputs are registered; valid never drops before ready.

## Configuration
- TILE_STALL_CNT_EN defined: stall_cnt increments (saturating at 2^32-1) every cycle spent in SEND, RECV, MREQ or MRSP without completing; cleared by reset.
- Not defined: stall_cnt tied to 0, no counter logic.

## Structure
- Package cgra_tile_pkg: opcode and ALU func localparams, FSM state enum, field-offset functions of (RW, DW, ADDR_W, DATA_W).
- One sub-module: cgra_pe_alu (combinational, DATA_W-parametrised, func → result).

## Test plan
- Reset then imm r1←5, imm r2←3, ALU add r3 → output r3: out_valid one cycle, out_data=8.
- ALU sub 3−5 at DATA_W=32 → 0xFFFFFFFE; lt(3,5)=1; func F → 0.
- Send r3 on E (dir 2) with tx_ready low 4 cycles: tx_valid[2] held with data 8, stall_cnt=4 (macro on), IDLE one cycle after ready.
- Receive dir 5 into r4, rx_valid[5] at cycle 3 with 0x1234, rx_valid[0] noise: only rx_ready[5] high, r4=0x1234.
- Store r1 to addr 0x3FF, then load addr 0x3FF into r6 with 2-cycle response delay: request fields correct, r6=5.
- Assert rst while in MRSP, then mem_rsp_valid: registers stay 0, state IDLE, instr_ready=1 next cycle.
